// File: rtl/time_of_day_if.sv
// Time-of-day control inputs and display outputs bundled as one port group.
interface time_of_day_if;
  logic       run;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] bin3;
  logic [3:0] bin2;
  logic [3:0] bin1;
  logic [3:0] bin0;
  logic       sec_tick;
  logic       min_tick;
  logic       colon;

  modport master (
    output run, set_mode, inc_min, inc_hour,
    input  bin3, bin2, bin1, bin0, sec_tick, min_tick, colon
  );

  modport slave (
    input  run, set_mode, inc_min, inc_hour,
    output bin3, bin2, bin1, bin0, sec_tick, min_tick, colon
  );
endinterface

// File: rtl/time_of_day.sv
// BCD hours:minutes timekeeper with second prescaler, set mode and colon blink.
// All outputs come straight from registers.
module time_of_day #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SECS_PER_MIN = 60
) (
  input  logic          clk,
  input  logic          reset,
  time_of_day_if.slave  tod
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SECS_PER_MIN > 2) ? $clog2(SECS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] COLON_LIM = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SEC_MAX   = SW'(SECS_PER_MIN - 1);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_sec;
  logic [3:0]    r_bin3, r_bin2, r_bin1, r_bin0;
  logic          r_sec_tick, r_min_tick, r_colon;
  logic          r_inc_min_d, r_inc_hour_d;

  logic          w_set, w_count;
  logic          w_presc_wrap, w_sec_wrap;
  logic          w_min_rise, w_hour_rise;
  logic          w_min_adv, w_hour_adv;
  logic [PW-1:0] w_presc_nxt;
  logic [SW-1:0] w_sec_nxt;
  logic [3:0]    w_bin3_nxt, w_bin2_nxt, w_bin1_nxt, w_bin0_nxt;
  logic          w_colon_nxt;

  assign w_set        = tod.set_mode;
  assign w_count      = tod.run & ~tod.set_mode;
  assign w_presc_wrap = w_count && (r_presc == PRESC_MAX);
  assign w_sec_wrap   = w_presc_wrap && (r_sec == SEC_MAX);

  // Button edges only count in set mode; the delayed copies track every cycle.
  assign w_min_rise  = w_set & tod.inc_min  & ~r_inc_min_d;
  assign w_hour_rise = w_set & tod.inc_hour & ~r_inc_hour_d;

  // Only a timekeeping minute wrap at :59 carries into the hours.
  assign w_min_adv  = w_sec_wrap | w_min_rise;
  assign w_hour_adv = (w_sec_wrap && r_bin1 == 4'd5 && r_bin0 == 4'd9) | w_hour_rise;

  always_comb begin
    w_presc_nxt = r_presc;
    w_sec_nxt   = r_sec;
    w_colon_nxt = 1'b1;
    w_bin3_nxt  = r_bin3;
    w_bin2_nxt  = r_bin2;
    w_bin1_nxt  = r_bin1;
    w_bin0_nxt  = r_bin0;

    if (w_set) begin
      w_presc_nxt = '0;
      w_sec_nxt   = '0;
    end else if (w_count) begin
      if (w_presc_wrap) begin
        w_presc_nxt = '0;
        w_sec_nxt   = (r_sec == SEC_MAX) ? '0 : r_sec + SW'(1);
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
      // Colon follows the prescaler value that will be held next cycle.
      w_colon_nxt = (w_presc_nxt < COLON_LIM);
    end

    if (w_min_adv) begin
      if (r_bin0 == 4'd9) begin
        w_bin0_nxt = 4'd0;
        w_bin1_nxt = (r_bin1 == 4'd5) ? 4'd0 : r_bin1 + 4'd1;
      end else begin
        w_bin0_nxt = r_bin0 + 4'd1;
      end
    end

    if (w_hour_adv) begin
      if (r_bin3 == 4'd2 && r_bin2 == 4'd3) begin
        w_bin3_nxt = 4'd0;
        w_bin2_nxt = 4'd0;
      end else if (r_bin2 == 4'd9) begin
        w_bin2_nxt = 4'd0;
        w_bin3_nxt = r_bin3 + 4'd1;
      end else begin
        w_bin2_nxt = r_bin2 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_sec        <= '0;
      r_bin3       <= 4'd0;
      r_bin2       <= 4'd0;
      r_bin1       <= 4'd0;
      r_bin0       <= 4'd0;
      r_sec_tick   <= 1'b0;
      r_min_tick   <= 1'b0;
      r_colon      <= 1'b1;
      r_inc_min_d  <= 1'b0;
      r_inc_hour_d <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_sec        <= w_sec_nxt;
      r_bin3       <= w_bin3_nxt;
      r_bin2       <= w_bin2_nxt;
      r_bin1       <= w_bin1_nxt;
      r_bin0       <= w_bin0_nxt;
      r_sec_tick   <= w_presc_wrap;
      r_min_tick   <= w_sec_wrap;
      r_colon      <= w_colon_nxt;
      r_inc_min_d  <= tod.inc_min;
      r_inc_hour_d <= tod.inc_hour;
    end
  end

  assign tod.bin3     = r_bin3;
  assign tod.bin2     = r_bin2;
  assign tod.bin1     = r_bin1;
  assign tod.bin0     = r_bin0;
  assign tod.sec_tick = r_sec_tick;
  assign tod.min_tick = r_min_tick;
  assign tod.colon    = r_colon;

endmodule

// File: tb/tb_time_of_day.sv
// Bench for time_of_day: directed scenarios plus random traffic against a
// minutes-of-day reference model.
module tb_time_of_day;

  localparam int TD  = 4;
  localparam int SPM = 3;

  logic clk;
  logic reset;
  time_of_day_if tod();

  time_of_day #(.TICK_DIV(TD), .SECS_PER_MIN(SPM)) dut (
    .clk   (clk),
    .reset (reset),
    .tod   (tod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: time held as minutes since midnight.
  int m_presc, m_sec, m_tmin;
  bit m_st, m_mt, m_col, m_pm, m_ph;

  function automatic logic [15:0] digits_of(input int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return 16'((h / 10) * 4096 + (h % 10) * 256 + (m / 10) * 16 + (m % 10));
  endfunction

  function automatic logic [15:0] dut_digits();
    return {tod.bin3, tod.bin2, tod.bin1, tod.bin0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pm_now, ph_now;
    pm_now = tod.inc_min;
    ph_now = tod.inc_hour;
    if (reset) begin
      m_presc = 0; m_sec = 0; m_tmin = 0;
      m_st = 0; m_mt = 0; m_col = 1;
    end else begin
      m_st = 0; m_mt = 0; m_col = 1;
      if (tod.set_mode) begin
        m_presc = 0; m_sec = 0;
        if (pm_now && !m_pm) m_tmin = (m_tmin / 60) * 60 + (m_tmin % 60 + 1) % 60;
        if (ph_now && !m_ph) m_tmin = ((m_tmin / 60 + 1) % 24) * 60 + m_tmin % 60;
      end else if (tod.run) begin
        m_presc++;
        if (m_presc == TD) begin
          m_presc = 0;
          m_st = 1;
          m_sec++;
          if (m_sec == SPM) begin
            m_sec = 0;
            m_mt = 1;
            m_tmin = (m_tmin + 1) % 1440;
          end
        end
        m_col = (m_presc < TD / 2);
      end
    end
    m_pm = reset ? 1'b0 : pm_now;
    m_ph = reset ? 1'b0 : ph_now;
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("digits",   dut_digits(),        digits_of(m_tmin));
    chk("sec_tick", 16'(tod.sec_tick),   16'(m_st));
    chk("min_tick", 16'(tod.min_tick),   16'(m_mt));
    chk("colon",    16'(tod.colon),      16'(m_col));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tod.run = 1'b0; tod.set_mode = 1'b0; tod.inc_min = 1'b0; tod.inc_hour = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse_min();
    tod.inc_min = 1'b1; step();
    tod.inc_min = 1'b0; step();
  endtask

  task automatic pulse_hour();
    tod.inc_hour = 1'b1; step();
    tod.inc_hour = 1'b0; step();
  endtask

  task automatic set_time(input int h, input int m);
    tod.set_mode = 1'b1;
    tod.run = 1'b0;
    for (int i = 0; i < 24 && (m_tmin / 60) != h; i++) pulse_hour();
    for (int i = 0; i < 60 && (m_tmin % 60) != m; i++) pulse_min();
    chk("set_time", dut_digits(), 16'((h / 10) * 4096 + (h % 10) * 256 + (m / 10) * 16 + (m % 10)));
  endtask

  initial begin
    int mt_cnt;
    reset = 1'b1;
    tod.run = 1'b0; tod.set_mode = 1'b0; tod.inc_min = 1'b0; tod.inc_hour = 1'b0;
    m_pm = 0; m_ph = 0;

    // Reset state and first minute from reset release
    do_reset();
    chk("rst_digits", dut_digits(), 16'h0000);
    chk("rst_colon",  16'(tod.colon), 16'h1);
    tod.run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("t1_sec_tick", 16'(tod.sec_tick), 16'((c % 4) == 0));
      chk("t1_colon",    16'(tod.colon),    16'((c % 4) < 2));
    end
    chk("t1_min_tick", 16'(tod.min_tick), 16'h1);
    chk("t1_digits",   dut_digits(),      16'h0001);

    // 23:59 rolls over to 00:00 with a single min_tick
    do_reset();
    set_time(23, 59);
    tod.set_mode = 1'b0;
    tod.run = 1'b1;
    mt_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      mt_cnt += int'(tod.min_tick);
    end
    chk("t2_min_ticks", 16'(mt_cnt), 16'd1);
    chk("t2_digits",    dut_digits(), 16'h0000);

    // Set-mode wraps and simultaneous increments
    do_reset();
    set_time(12, 59);
    pulse_min();
    chk("t3_min_wrap", dut_digits(), 16'h1200);
    set_time(23, 0);
    pulse_hour();
    chk("t3_hour_wrap", dut_digits(), 16'h0000);
    set_time(9, 59);
    tod.inc_min = 1'b1; tod.inc_hour = 1'b1;
    step();
    chk("t3_both", dut_digits(), 16'h1000);
    tod.inc_min = 1'b0; tod.inc_hour = 1'b0;
    step();

    // Held button gives one increment; edge outside set mode is dropped
    tod.inc_min = 1'b1;
    repeat (20) step();
    tod.inc_min = 1'b0;
    step();
    chk("t4_held", dut_digits(), 16'h1001);
    tod.set_mode = 1'b0;
    step();
    tod.inc_min = 1'b1;
    step();
    tod.set_mode = 1'b1;
    repeat (3) step();
    chk("t4_stale_edge", dut_digits(), 16'h1001);
    tod.inc_min = 1'b0;
    tod.set_mode = 1'b0;
    step();

    // Run paused for 7 cycles after cycle 6
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tod.run = !(c >= 7 && c <= 13);
      step();
      chk("t5_sec_tick", 16'(tod.sec_tick), 16'(c == 4 || c == 15 || c == 19));
    end

    // Set mode entered on the wrap edge suppresses the strobe
    do_reset();
    tod.run = 1'b1;
    repeat (3) step();
    tod.set_mode = 1'b1;
    step();
    chk("t_set_on_wrap", 16'(tod.sec_tick), 16'h0);
    tod.set_mode = 1'b0;

    // Reset mid-count and mid-set
    do_reset();
    set_time(5, 37);
    tod.set_mode = 1'b0;
    tod.run = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("t6_digits", dut_digits(), 16'h0000);
    chk("t6_strobes", 16'({tod.sec_tick, tod.min_tick}), 16'h0);
    chk("t6_colon", 16'(tod.colon), 16'h1);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t6_restart", 16'(tod.sec_tick), 16'(c == 4));
    end
    tod.set_mode = 1'b1;
    pulse_min();
    reset = 1'b1;
    step();
    chk("t6_set_reset", dut_digits(), 16'h0000);
    reset = 1'b0;
    tod.set_mode = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      tod.run      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) tod.set_mode = ~tod.set_mode;
      tod.inc_min  = ($urandom_range(0, 2) == 0);
      tod.inc_hour = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
